// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: bus widths, register
// offsets, FSM state encoding and the address decode helper.
package int_ctrl_pkg;

   localparam int NUM_SRC       = 8;
   localparam int INT_BUS       = NUM_SRC;
   localparam int INST_ADDR_BUS = 32;
   localparam int INST_DATA_BUS = 32;

   // Byte offsets of the register file
   localparam logic [3:0] IE_OFF    = 4'h0;
   localparam logic [3:0] IP_OFF    = 4'h4;
   localparam logic [3:0] CLAIM_OFF = 4'h8;
   localparam logic [3:0] CTRL_OFF  = 4'hC;

   // Word index of each register, as seen on address bits [3:2]
   localparam logic [1:0] REG_IE    = IE_OFF[3:2];
   localparam logic [1:0] REG_IP    = IP_OFF[3:2];
   localparam logic [1:0] REG_CLAIM = CLAIM_OFF[3:2];
   localparam logic [1:0] REG_CTRL  = CTRL_OFF[3:2];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } int_state_e;

   function automatic logic [1:0] reg_sel(input logic [INST_ADDR_BUS-1:0] addr);
      return addr[3:2];
   endfunction

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// Per-source two-flop synchronizer followed by an edge register; edge_o is a
// one-cycle pulse for every synchronized low-to-high transition.
module int_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] s3_q, s3_d;

   always_comb begin
      s1_d = async_i;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-triggered pending bits, enable mask, global
// enable, and a fixed-priority single-outstanding request/claim sequence.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = int_ctrl_pkg::NUM_SRC
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_SRC-1:0]       irq_src_i,
   input  logic                     wen_i,
   input  logic [INST_ADDR_BUS-1:0] waddr_i,
   input  logic [INST_DATA_BUS-1:0] wdata_i,
   input  logic [INST_ADDR_BUS-1:0] raddr_i,
   output logic [INST_DATA_BUS-1:0] rdata_o,
   output logic [NUM_SRC-1:0]       int_flag_o,
   input  logic                     int_ack_i
);

   localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   int_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] ie_q, ie_d;
   logic [NUM_SRC-1:0] ip_q, ip_d;
   logic               gie_q, gie_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_SRC-1:0] flag_q, flag_d;

   logic [NUM_SRC-1:0] edge_w;
   logic [NUM_SRC-1:0] pend_w;
   logic [ID_W-1:0]    low_id_w;
   logic [NUM_SRC-1:0] ack_clr_w;
   logic [NUM_SRC-1:0] w1c_w;
   logic               we_ie, we_ip, we_claim, we_ctrl;
   logic               claim_match_w;

   int_sync_edge #(.WIDTH(NUM_SRC)) u_sync_edge (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (irq_src_i),
      .edge_o  (edge_w)
   );

   always_comb begin
      we_ie         = wen_i && (reg_sel(waddr_i) == REG_IE);
      we_ip         = wen_i && (reg_sel(waddr_i) == REG_IP);
      we_claim      = wen_i && (reg_sel(waddr_i) == REG_CLAIM);
      we_ctrl       = wen_i && (reg_sel(waddr_i) == REG_CTRL);
      claim_match_w = we_claim && (wdata_i[ID_W-1:0] == id_q);
   end

   // Lowest index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      pend_w   = ip_q & ie_q;
      low_id_w = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend_w[i]) low_id_w = ID_W'(i);
      end
   end

   // int_flag_o/int_ack_i handshake: the one-hot flag is held for as long as
   // the FSM sits in REQ; int_ack_i is only honoured in a cycle where the
   // flag is high, and the request is considered transferred on that edge.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      ack_clr_w = '0;
      case (state_q)
         IDLE: begin
            if (gie_q && (|pend_w)) begin
               id_d    = low_id_w;
               state_d = REQ;
            end
         end
         REQ: begin
            if (int_ack_i) begin
               ack_clr_w[id_q] = 1'b1;
               state_d         = SERVICE;
            end else if (!gie_q || !ie_q[id_q]) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (claim_match_w) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ie_d  = ie_q;
      gie_d = gie_q;
      w1c_w = '0;
      if (we_ie)   ie_d  = wdata_i[NUM_SRC-1:0];
      if (we_ctrl) gie_d = wdata_i[0];
      if (we_ip)   w1c_w = wdata_i[NUM_SRC-1:0];
      // A new edge in the same cycle as a clear keeps the bit set.
      ip_d = (ip_q & ~w1c_w & ~ack_clr_w) | edge_w;
   end

   // Registered flag so the core sees a glitch-free one-hot request.
   always_comb begin
      flag_d = '0;
      if (state_d == REQ) flag_d[id_d] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ie_q    <= '0;
         ip_q    <= '0;
         gie_q   <= 1'b0;
         id_q    <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         ip_q    <= ip_d;
         gie_q   <= gie_d;
         id_q    <= id_d;
         flag_q  <= flag_d;
      end
   end

   assign int_flag_o = flag_q;

   always_comb begin
      rdata_o = '0;
      case (reg_sel(raddr_i))
         REG_IE:  rdata_o[NUM_SRC-1:0] = ie_q;
         REG_IP:  rdata_o[NUM_SRC-1:0] = ip_q;
         REG_CLAIM: begin
            rdata_o[INST_DATA_BUS-1] = (state_q == SERVICE);
            rdata_o[ID_W-1:0]        = id_q;
         end
         REG_CTRL: rdata_o[0] = gie_q;
         default:  rdata_o = '0;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{waddr_i[INST_ADDR_BUS-1:4], waddr_i[1:0],
                          raddr_i[INST_ADDR_BUS-1:4], raddr_i[1:0],
                          wdata_i[INST_DATA_BUS-1:NUM_SRC]};

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: register vector table, directed corner
// sequences and randomized multi-source rounds against a service-order model.
module tb_int_ctrl;

   localparam int N = 8;
   localparam logic [31:0] A_IE    = 32'h0;
   localparam logic [31:0] A_IP    = 32'h4;
   localparam logic [31:0] A_CLAIM = 32'h8;
   localparam logic [31:0] A_CTRL  = 32'hC;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [N-1:0]  irq_src_i;
   logic          wen_i;
   logic [31:0]   waddr_i;
   logic [31:0]   wdata_i;
   logic [31:0]   raddr_i;
   logic [31:0]   rdata_o;
   logic [N-1:0]  int_flag_o;
   logic          int_ack_i;

   int checks   = 0;
   int failures = 0;

   int_ctrl #(.NUM_SRC(N)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .irq_src_i  (irq_src_i),
      .wen_i      (wen_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .raddr_i    (raddr_i),
      .rdata_o    (rdata_o),
      .int_flag_o (int_flag_o),
      .int_ack_i  (int_ack_i)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- driver / check tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_i);
      wen_i   = 1'b1;
      waddr_i = a;
      wdata_i = d;
      @(negedge clk_i);
      wen_i   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      raddr_i = a;
      #1;
      d = rdata_o;
   endtask

   task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic raise(input logic [N-1:0] m);
      @(negedge clk_i);
      irq_src_i = irq_src_i | m;
   endtask

   task automatic lower(input logic [N-1:0] m);
      @(negedge clk_i);
      irq_src_i = irq_src_i & ~m;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic wait_flag(input logic [N-1:0] exp, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (int_flag_o == '0 && n < 20);
      check(name, 32'(int_flag_o), 32'(exp));
   endtask

   task automatic ack();
      @(negedge clk_i);
      int_ack_i = 1'b1;
      @(negedge clk_i);
      int_ack_i = 1'b0;
   endtask

   // ---------------- register vector table ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];

   initial begin
      logic [N-1:0] ie, mask, pending, oh;
      logic [31:0]  id;

      rst_i     = 1'b1;
      irq_src_i = '0;
      wen_i     = 1'b0;
      waddr_i   = '0;
      wdata_i   = '0;
      raddr_i   = '0;
      int_ack_i = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk_i);
      check("rst_flag", 32'(int_flag_o), 32'h0);
      check_rd("rst_ie", A_IE, 32'h0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_rd("rst_ip", A_IP, 32'h0);
      check_rd("rst_claim", A_CLAIM, 32'h0);
      check_rd("rst_ctrl", A_CTRL, 32'h0);

      // ---- register table ----
      vecs[0]  = '{1'b1, A_IE,     32'h0000_00A5, 32'h0000_00A5};
      vecs[1]  = '{1'b1, A_IE,     32'hFFFF_FF3C, 32'h0000_003C};
      vecs[2]  = '{1'b0, A_IP,     32'h0,         32'h0};
      vecs[3]  = '{1'b1, A_CTRL,   32'hFFFF_FFFE, 32'h0};
      vecs[4]  = '{1'b1, A_CTRL,   32'h0000_0001, 32'h1};
      vecs[5]  = '{1'b0, A_CLAIM,  32'h0,         32'h0};
      vecs[6]  = '{1'b1, A_IP,     32'h0000_00FF, 32'h0};
      vecs[7]  = '{1'b1, A_CTRL,   32'h0,         32'h0};
      vecs[8]  = '{1'b1, 32'h10,   32'h0000_005A, 32'h0000_005A};
      vecs[9]  = '{1'b0, A_IE,     32'h0,         32'h0000_005A};
      vecs[10] = '{1'b1, A_IE,     32'h0,         32'h0};
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
         @(negedge clk_i);
         check_rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // ---- single source, exact latency, ack and complete ----
      wr(A_IE, 32'h01);
      wr(A_CTRL, 32'h1);
      @(negedge clk_i);
      irq_src_i[0] = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      check_rd("lat_ip_e2", A_IP, 32'h0);
      @(negedge clk_i);
      check_rd("lat_ip_e3", A_IP, 32'h1);
      check("lat_flag_e3", 32'(int_flag_o), 32'h0);
      @(negedge clk_i);
      check("lat_flag_e4", 32'(int_flag_o), 32'h1);
      ack();
      check_rd("ack_ip", A_IP, 32'h0);
      check_rd("ack_claim", A_CLAIM, 32'h8000_0000);
      check("svc_flag", 32'(int_flag_o), 32'h0);
      wr(A_CLAIM, 32'h0);
      check_rd("done_claim", A_CLAIM, 32'h0);
      lower(8'h01);

      // ---- two sources together: priority order ----
      wr(A_IE, 32'hFF);
      raise(8'h28);
      wait_flag(8'h08, "prio_first");
      ack();
      check_rd("prio_ip_left", A_IP, 32'h20);
      wr(A_CLAIM, 32'h3);
      wait_flag(8'h20, "prio_second");
      ack();
      wr(A_CLAIM, 32'h5);
      check_rd("prio_ip_end", A_IP, 32'h0);
      lower(8'h28);

      // ---- IE withdrawn while requesting ----
      raise(8'h04);
      wait_flag(8'h04, "iew_flag");
      wr(A_IE, 32'hFB);
      @(negedge clk_i);
      check("iew_flag_drop", 32'(int_flag_o), 32'h0);
      check_rd("iew_ip_kept", A_IP, 32'h04);
      check_rd("iew_claim", A_CLAIM, 32'h2);
      wr(A_IP, 32'h04);
      check_rd("iew_ip_w1c", A_IP, 32'h0);
      lower(8'h04);

      // ---- W1C collides with edge set ----
      wr(A_CTRL, 32'h0);
      @(negedge clk_i);
      irq_src_i[2] = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      wen_i   = 1'b1;
      waddr_i = A_IP;
      wdata_i = 32'h04;
      @(negedge clk_i);
      wen_i = 1'b0;
      check_rd("w1c_set_wins", A_IP, 32'h04);
      wr(A_IP, 32'h04);
      check_rd("w1c_after", A_IP, 32'h0);
      lower(8'h04);

      // ---- ack-clear collides with edge set ----
      wr(A_IE, 32'hFF);
      wr(A_CTRL, 32'h1);
      raise(8'h08);
      wait_flag(8'h08, "ackc_flag");
      lower(8'h08);
      @(negedge clk_i);
      irq_src_i[3] = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      int_ack_i = 1'b1;
      @(negedge clk_i);
      int_ack_i = 1'b0;
      check_rd("ackc_set_wins", A_IP, 32'h08);
      check_rd("ackc_claim", A_CLAIM, 32'h8000_0003);
      wr(A_CLAIM, 32'h3);
      wait_flag(8'h08, "ackc_again");
      ack();
      wr(A_CLAIM, 32'h3);
      check_rd("ackc_ip_end", A_IP, 32'h0);
      lower(8'h08);

      // ---- wrong-id claim ignored ----
      raise(8'h02);
      wait_flag(8'h02, "wid_flag");
      ack();
      wr(A_CLAIM, 32'h6);
      check_rd("wid_still_svc", A_CLAIM, 32'h8000_0001);
      wr(A_CLAIM, 32'h1);
      check_rd("wid_done", A_CLAIM, 32'h1);
      lower(8'h02);

      // ---- reset during SERVICE ----
      raise(8'h10);
      wait_flag(8'h10, "rsvc_flag");
      ack();
      check_rd("rsvc_claim", A_CLAIM, 32'h8000_0004);
      @(negedge clk_i);
      rst_i     = 1'b1;
      irq_src_i = '0;
      #1;
      check("rsvc_flag0", 32'(int_flag_o), 32'h0);
      check_rd("rsvc_claim0", A_CLAIM, 32'h0);
      check_rd("rsvc_ie0", A_IE, 32'h0);
      check_rd("rsvc_ctrl0", A_CTRL, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      check_rd("rsvc_ip0", A_IP, 32'h0);
      check("rsvc_flag_after", 32'(int_flag_o), 32'h0);

      // ---- randomized rounds against a service-order model ----
      for (int r = 0; r < 20; r++) begin
         ie   = N'($urandom_range(0, 255));
         mask = N'($urandom_range(1, 255));
         wr(A_IE, 32'(ie));
         wr(A_CTRL, 32'h1);
         raise(mask);
         pending = mask;
         exp_q.delete();
         for (int i = 0; i < N; i++) begin
            if (mask[i] && ie[i]) exp_q.push_back(32'(i));
         end
         while (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            oh = '0;
            oh[id[2:0]] = 1'b1;
            wait_flag(oh, $sformatf("rnd%0d_flag", r));
            ack();
            pending[id[2:0]] = 1'b0;
            check_rd($sformatf("rnd%0d_ip", r), A_IP, 32'(pending));
            check_rd($sformatf("rnd%0d_claim", r), A_CLAIM, 32'h8000_0000 | id);
            wr(A_CLAIM, id);
         end
         repeat (6) @(negedge clk_i);
         check($sformatf("rnd%0d_quiet", r), 32'(int_flag_o), 32'h0);
         check_rd($sformatf("rnd%0d_left", r), A_IP, 32'(mask & ~ie));
         wr(A_CTRL, 32'h0);
         wr(A_IP, 32'hFF);
         lower(mask);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning the number of interrupt sources; it is fixed equal to the INT_BUS width.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous reset, active-high.
REQ-004 SHALL have port irq_src_i, input, NUM_SRC bits: asynchronous level sources; a rising edge requests service.
REQ-005 SHALL have port wen_i, input, 1 bit: register write strobe from the rib slave port.
REQ-006 SHALL have port waddr_i, input, INST_ADDR_BUS width: write address; only bits [3:2] are decoded.
REQ-007 SHALL have port wdata_i, input, INST_DATA_BUS width: write data.
REQ-008 SHALL have port raddr_i, input, INST_ADDR_BUS width: read address; only bits [3:2] are decoded.
REQ-009 SHALL have port rdata_o, output, INST_DATA_BUS width: combinational read data.
REQ-010 SHALL have port int_flag_o, output, INT_BUS width: one-hot interrupt to the core int_flag_i.
REQ-011 SHALL have port int_ack_i, input, 1 bit: the core has taken the presented interrupt.

Function
REQ-012 SHALL pass each source through a 2-flop synchronizer plus an edge register; a rising edge sets IP[n] on the third clock after the first sampling high.
REQ-013 SHALL provide register IE at offset 0x0: R/W bits [NUM_SRC-1:0], upper bits read 0.
REQ-014 SHALL provide register IP at offset 0x4: read-only pending bits, write-1-to-clear.
REQ-015 SHALL provide register CLAIM at offset 0x8 with read = {bit31 in_service, bits[2:0] id}; a write with wdata[2:0] equal to the in-service id completes service, and a write with any other id is ignored.
REQ-016 SHALL provide register CTRL at offset 0xC: bit0 is GIE; other bits read 0.
REQ-017 SHALL use FSM states IDLE, REQ and SERVICE.
REQ-018 SHALL, in IDLE, when GIE=1 and |(IP&IE), latch id = lowest set index of (IP&IE) and move to REQ on the next edge.
REQ-019 SHALL, in REQ, drive int_flag_o = onehot(id); on int_ack_i, clear IP[id] and go to SERVICE.
REQ-020 SHALL, in REQ without ack, return to IDLE if GIE or IE[id] is cleared; IP[id] is kept and int_flag_o drops the next cycle.
REQ-021 SHALL, in SERVICE, drive int_flag_o=0, set CLAIM.in_service=1, and return to IDLE on a matching CLAIM write.
REQ-022 SHALL ignore int_ack_i outside REQ.
REQ-023 SHALL let a set win when an edge set and a W1C or ack-clear hit the same IP bit in the same cycle.
REQ-024 SHALL delay int_flag_o by exactly 1 cycle from IDLE exit, and issue no back-to-back interrupt without passing through IDLE.
REQ-025 SHALL hold the latched id when higher-priority pending bits arrive during REQ or SERVICE (no preemption).
REQ-026 SHALL return 0 on reads of undecoded offsets.

Reset
REQ-027 SHALL, on rst_i, force state IDLE, IE=0, IP=0, GIE=0, id=0, synchronizers=0 and int_flag_o=0; rdata_o then reflects the reset registers.
REQ-028 SHALL, on reset mid-REQ or mid-SERVICE, abandon service immediately with no pending state retained.

Structure
REQ-029 SHALL place register offsets, the FSM state enum and NUM_SRC in the shared define package.
REQ-030 SHALL implement one sub-module, int_sync_edge: a per-source synchronizer plus rising-edge detector.

Verification
REQ-031 SHALL cover: IE=0x01, GIE=1, pulse src0 -> int_flag_o=0x01 at cycle 4; ack -> IP=0, CLAIM=0x80000000; write CLAIM 0 -> IDLE.
REQ-032 SHALL cover: src3 and src5 rise together, IE=0xFF -> id=3 served first, then id=5 after complete.
REQ-033 SHALL cover: in REQ with id=2, clear IE[2] -> int_flag_o=0 next cycle, IP[2] still 1.
REQ-034 SHALL cover: write IP=0x04 in the same cycle src2 edge is detected -> IP[2]=1.
REQ-035 SHALL cover: CLAIM write with id 6 while servicing 1 -> remains in SERVICE.
REQ-036 SHALL cover: assert rst_i during SERVICE -> all outputs 0 and CLAIM reads 0.
